nou_rsp_arb: RTL and testbench
==============================

// Module: nou_rsp_arb
// PURPOSE
//  Shares the single outbound response channel into or_encode among N RPU receive controllers.
//  Each controller presents a response (type/status/err).
//  The arbiter grants round-robin, optionally error-first, and registers the winner onto ob_rsp_*.
//  It holds that response until or_ready, then acks the winner.
//  Sits between the per-channel rpu control FSMs and or_encode.
// PARAMETERS
//  N_REQ      4      number of requesters, >=1
//  ERR_FIRST  1      1: status==ERR requests win over OK requests; 0: plain round-robin
//  TICK_HOLD  11000  HOLD cycles without or_ready before timeout is flagged
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      synchronous, active-high reset
//  req_vld      in   N_REQ                  requester i has a response pending
//  req_type     in   N_REQ*NOU_TYPE_WIDTH   per-requester type, slice i
//  req_status   in   N_REQ                  per-requester status (RSP_STATUS_OK/ERR)
//  req_err      in   N_REQ*NOU_ERR_CODE_WIDTH  per-requester error code, slice i
//  req_ack      out  N_REQ                  one-hot pulse: requester i's response accepted downstream
//  or_ready     in   1                      or_encode accepts ob_rsp_* this cycle
//  ob_rsp_vld   out  1                      response valid to or_encode
//  ob_rsp_type  out  NOU_TYPE_WIDTH         registered type of granted requester
//  ob_rsp_status out 1                      registered status
//  ob_rsp_err   out  NOU_ERR_CODE_WIDTH     registered error code
//  grant_id     out  $clog2(N_REQ) (min 1)  index of current grant, valid while ob_rsp_vld
//  timeout      out  1                      sticky: HOLD exceeded TICK_HOLD
//  timeout_clr  in   1                      clears timeout
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, ob_rsp_* =0, grant_id=0, req_ack=0, timeout=0, hold_cnt=0.
//  FSM IDLE:
//   - if |req_vld, pick winner w, latch req_*[w] into ob_rsp_type/status/err and grant_id=w.
//   - Go to HOLD; ob_rsp_vld=1 from next cycle (1-cycle grant latency).
//  Winner selection:
//   - ERR_FIRST=1 and any vld requester has status ERR: pick the first ERR requester at/after rr_ptr.
//   - Otherwise: pick the first vld requester at/after rr_ptr (wrap N_REQ-1 -> 0).
//  FSM HOLD:
//   - ob_rsp_vld=1, outputs stable.
//   - On or_ready: req_ack[grant_id]=1 combinationally that cycle, rr_ptr<=(grant_id+1)%N_REQ, hold_cnt<=0, ->IDLE.
//   - Throughput is one response per 2 cycles min.
//  req_ack is one-hot or zero; never asserted in IDLE.
//  Requesters hold vld/fields until ack; changes after latch are ignored.
//  A winner that drops vld during HOLD still gets its response sent and acked.
//  hold_cnt increments each HOLD cycle without or_ready, saturating at TICK_HOLD.
//  On reaching TICK_HOLD: timeout<=1 (sticky). Response is NOT dropped; HOLD continues.
//  timeout_clr clears timeout next cycle; simultaneous set+clr: set wins.
//  Arbitration is evaluated only in IDLE; new arrivals during HOLD wait.
//  N_REQ=1: rr_ptr constant 0, behaves as a registered pass-through with ack.
//  rst in any state returns to the reset values next edge. An in-flight response is lost; no ack issued.
// STRUCTURE
//  Package nou_rsp_arb_pkg:
//   - arb_state_t {IDLE, HOLD}
//   - default TICK_HOLD
//   - slice-index helper function
//  Widths/codes come from nou_define.h: NOU_TYPE_WIDTH, NOU_ERR_CODE_WIDTH, RSP_STATUS_*.
//  Sub-module nou_rr_pick: combinational round-robin first-set picker.
//   - Inputs: mask[N], ptr. Outputs: any, idx.
//   - Instantiated twice (ERR mask, vld mask); the ERR result is muxed in when ERR_FIRST and any-ERR.
// TESTING
//  1) Single req: req_vld=0001, type=1, or_ready=1 held.
//     -> ob_rsp_vld at t+1, type=1, grant_id=0, req_ack=0001 at t+1, rr_ptr=1.
//  2) All four vld, all OK, or_ready=1, each requester drops vld after ack.
//     -> grants 0,1,2,3 in order, one every 2 cycles.
//  3) ERR_FIRST: vld=1111, req 2 status ERR err=5, rr_ptr=0.
//     -> grant 2 first, ob_rsp_status=1, err=5; then 3,0,1.
//  4) or_ready low for TICK_HOLD cycles.
//     -> timeout=1 at cycle TICK_HOLD, ob_rsp_vld stays 1.
//     -> or_ready then acks normally; timeout_clr clears the flag.
//  5) Winner drops vld mid-HOLD, req 1 raises vld.
//     -> original response still sent and acked; req 1 is granted only after return to IDLE.
//  6) rst asserted in HOLD.
//     -> next cycle ob_rsp_vld=0, req_ack=0, rr_ptr=0, timeout=0.

Source files
------------

// File: rtl/nou_rsp_arb_pkg.sv
// Shared types, response field widths and helpers for the response-channel arbiter.
package nou_rsp_arb_pkg;

    localparam int   NOU_TYPE_WIDTH     = 4;
    localparam int   NOU_ERR_CODE_WIDTH = 8;
    localparam logic RSP_STATUS_OK      = 1'b0;
    localparam logic RSP_STATUS_ERR     = 1'b1;

    localparam int   TICK_HOLD_DFLT     = 11000;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    // Low bit of slice idx in a flat bus of w-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/nou_rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module nou_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] rot;

    // Rotating the doubled mask puts the ptr position at bit 0.
    assign rot = {mask, mask} >> ptr;
    assign any = |mask;

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) idx = IDW'((int'(ptr) + i) % N);
        end
    end

endmodule

// File: rtl/nou_rsp_arb.sv
// Arbitrates N response requesters onto the single registered or_encode channel.
module nou_rsp_arb
    import nou_rsp_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int ERR_FIRST = 1,
    parameter  int TICK_HOLD = TICK_HOLD_DFLT,
    localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TW        = NOU_TYPE_WIDTH,
    localparam int EW        = NOU_ERR_CODE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_vld,
    input  logic [N_REQ*TW-1:0] req_type,
    input  logic [N_REQ-1:0]  req_status,
    input  logic [N_REQ*EW-1:0] req_err,
    output logic [N_REQ-1:0]  req_ack,
    input  logic              or_ready,
    output logic              ob_rsp_vld,
    output logic [TW-1:0]     ob_rsp_type,
    output logic              ob_rsp_status,
    output logic [EW-1:0]     ob_rsp_err,
    output logic [IDW-1:0]    grant_id,
    output logic              timeout,
    input  logic              timeout_clr
);

    localparam int CW = $clog2(TICK_HOLD + 1);

    arb_state_t       state, state_nxt;
    logic [IDW-1:0]   rr_ptr, ptr_inc;
    logic [CW-1:0]    hold_cnt;
    logic [N_REQ-1:0] err_mask;
    logic             err_any, vld_any;
    logic [IDW-1:0]   err_idx, vld_idx, win;
    logic             ack_fire, tmo_set;

    for (genvar g = 0; g < N_REQ; g++) begin : g_err
        assign err_mask[g] = req_vld[g] && (req_status[g] == RSP_STATUS_ERR);
    end

    nou_rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick_err (
        .mask(err_mask), .ptr(rr_ptr), .any(err_any), .idx(err_idx)
    );

    nou_rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick_vld (
        .mask(req_vld), .ptr(rr_ptr), .any(vld_any), .idx(vld_idx)
    );

    assign win        = (ERR_FIRST != 0 && err_any) ? err_idx : vld_idx;
    assign ack_fire   = (state == HOLD) && or_ready;
    assign tmo_set    = (state == HOLD) && !or_ready && (hold_cnt == CW'(TICK_HOLD - 1));
    assign ob_rsp_vld = (state == HOLD);
    assign ptr_inc    = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;

    // Ack is suppressed under reset so an in-flight response is never acked.
    always_comb begin
        req_ack = '0;
        if (ack_fire && !rst) req_ack[grant_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vld_any)  state_nxt = HOLD;
            HOLD:    if (or_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            grant_id      <= '0;
            ob_rsp_type   <= '0;
            ob_rsp_status <= 1'b0;
            ob_rsp_err    <= '0;
            hold_cnt      <= '0;
            timeout       <= 1'b0;
        end else begin
            if (state == IDLE && vld_any) begin
                ob_rsp_type   <= req_type[slice_lo(int'(win), TW) +: TW];
                ob_rsp_status <= req_status[win];
                ob_rsp_err    <= req_err[slice_lo(int'(win), EW) +: EW];
                grant_id      <= win;
            end
            if (ack_fire) rr_ptr <= ptr_inc;
            if (state == HOLD && !or_ready) begin
                if (hold_cnt != CW'(TICK_HOLD)) hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
            if (tmo_set)          timeout <= 1'b1;
            else if (timeout_clr) timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nou_rsp_arb.sv
// Scoreboard bench for nou_rsp_arb: expected grants queued at stimulus, checked on handshake.
module tb_nou_rsp_arb;
    import nou_rsp_arb_pkg::*;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int TW = NOU_TYPE_WIDTH;
    localparam int EW = NOU_ERR_CODE_WIDTH;

    typedef struct {
        int id;
        int typ;
        int st;
        int err;
    } exp_t;

    logic            clk, rst;
    logic [N-1:0]    req_vld, req_status, req_ack;
    logic [N*TW-1:0] req_type;
    logic [N*EW-1:0] req_err;
    logic            or_ready, ob_rsp_vld, ob_rsp_status, timeout, timeout_clr;
    logic [TW-1:0]   ob_rsp_type;
    logic [EW-1:0]   ob_rsp_err;
    logic [1:0]      grant_id;

    exp_t sb[$];
    int   ack_cyc[$];
    int   cyc = 0, checks = 0, failures = 0;
    bit   auto_drop = 1, mon_en = 1;

    nou_rsp_arb #(.N_REQ(N), .ERR_FIRST(1), .TICK_HOLD(T)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_type(req_type),
        .req_status(req_status), .req_err(req_err), .req_ack(req_ack),
        .or_ready(or_ready), .ob_rsp_vld(ob_rsp_vld), .ob_rsp_type(ob_rsp_type),
        .ob_rsp_status(ob_rsp_status), .ob_rsp_err(ob_rsp_err), .grant_id(grant_id),
        .timeout(timeout), .timeout_clr(timeout_clr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input int typ, input logic st, input int err);
        req_vld[i]            = 1'b1;
        req_type[i*TW +: TW]  = TW'(typ);
        req_status[i]         = st;
        req_err[i*EW +: EW]   = EW'(err);
    endtask

    task automatic push(input int id, input int typ, input int st, input int err);
        exp_t e;
        e.id = id; e.typ = typ; e.st = st; e.err = err;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1; req_vld = '0; req_status = '0; req_type = '0; req_err = '0;
        or_ready = 0; timeout_clr = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, sb.size(), 0);
    endtask

    // Handshake monitor: each accepted response must match the oldest expected grant.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (ob_rsp_vld && or_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack",    req_ack, 32'(1) << e.id);
                    chk("gid",    grant_id, e.id);
                    chk("type",   ob_rsp_type, e.typ);
                    chk("status", ob_rsp_status, e.st);
                    chk("err",    ob_rsp_err, e.err);
                    ack_cyc.push_back(cyc);
                    if (auto_drop) req_vld[e.id] = 1'b0;
                end
            end else begin
                chk("ack_idle", req_ack, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_vld", ob_rsp_vld, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_type", ob_rsp_type, 0);
        chk("rst_err", ob_rsp_err, 0);

        // 1) single requester, one-cycle grant latency
        or_ready = 1;
        set_req(0, 1, RSP_STATUS_OK, 0);
        push(0, 1, 0, 0);
        @(negedge clk);
        chk("t1_lat0", ob_rsp_vld, 0);
        @(posedge clk); #1;
        chk("t1_vld", ob_rsp_vld, 1);
        chk("t1_type", ob_rsp_type, 1);
        chk("t1_gid", grant_id, 0);
        chk("t1_ack", req_ack, 4'b0001);
        drain("t1_drain");

        // 2) all OK, round-robin order and 2-cycle throughput
        do_reset();
        or_ready = 1;
        ack_cyc.delete();
        for (int i = 0; i < N; i++) begin
            set_req(i, i + 1, RSP_STATUS_OK, 0);
            push(i, i + 1, 0, 0);
        end
        drain("t2_drain");
        chk("t2_nack", ack_cyc.size(), 4);
        if (ack_cyc.size() == 4)
            for (int k = 0; k < 3; k++) chk("t2_gap", ack_cyc[k+1] - ack_cyc[k], 2);

        // 3) error-first: req 2 jumps the queue, then round-robin from 3
        do_reset();
        or_ready = 1;
        for (int i = 0; i < N; i++) set_req(i, i + 4, RSP_STATUS_OK, 0);
        set_req(2, 6, RSP_STATUS_ERR, 5);
        push(2, 6, 1, 5); push(3, 7, 0, 0); push(0, 4, 0, 0); push(1, 5, 0, 0);
        drain("t3_drain");
        req_status = '0;

        // 4) hold timeout, set beats simultaneous clear, sticky after ack
        or_ready = 0;
        set_req(2, 7, RSP_STATUS_OK, 0);
        push(2, 7, 0, 0);
        @(posedge clk); #1;
        repeat (T - 1) @(posedge clk);
        #1;
        chk("t4_tmo_pre", timeout, 0);
        chk("t4_vld_pre", ob_rsp_vld, 1);
        timeout_clr = 1;
        @(posedge clk); #1;
        timeout_clr = 0;
        chk("t4_tmo_set", timeout, 1);
        chk("t4_vld_hold", ob_rsp_vld, 1);
        or_ready = 1;
        drain("t4_drain");
        chk("t4_sticky", timeout, 1);
        timeout_clr = 1;
        @(posedge clk); #1;
        timeout_clr = 0;
        chk("t4_clr", timeout, 0);

        // 5) winner drops vld mid-hold, late arrival waits for IDLE
        or_ready = 0;
        set_req(0, 3, RSP_STATUS_OK, 0);
        push(0, 3, 0, 0);
        @(posedge clk); #1;
        req_vld[0] = 1'b0;
        set_req(1, 9, RSP_STATUS_OK, 0);
        push(1, 9, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_vld", ob_rsp_vld, 1);
        chk("t5_gid", grant_id, 0);
        chk("t5_type", ob_rsp_type, 3);
        or_ready = 1;
        drain("t5_drain");

        // 6) reset during hold drops the response and the pointer
        or_ready = 0;
        set_req(0, 2, RSP_STATUS_OK, 0);
        @(posedge clk); #1;
        repeat (T) @(posedge clk);
        #1;
        chk("t6_tmo_pre", timeout, 1);
        mon_en = 0;
        or_ready = 1;
        rst = 1;
        @(negedge clk);
        chk("t6_ack_rst", req_ack, 0);
        @(posedge clk); #1;
        chk("t6_vld", ob_rsp_vld, 0);
        chk("t6_ack", req_ack, 0);
        chk("t6_tmo", timeout, 0);
        chk("t6_gid", grant_id, 0);
        chk("t6_type", ob_rsp_type, 0);
        rst = 0; req_vld = '0; or_ready = 0;
        @(posedge clk); #1;
        mon_en = 1;
        set_req(1, 10, RSP_STATUS_OK, 0);
        set_req(2, 11, RSP_STATUS_OK, 0);
        push(1, 10, 0, 0); push(2, 11, 0, 0);
        or_ready = 1;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
